// File: rtl/adder_master.sv
// Bus initiator for the full_adder register-file slave: programs DATA1/DATA2/CIN,
// pulses start, waits for ready, reads RESULT/COUT and returns them on a response port.
module adder_master #(
    parameter int N       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    input  logic         req_cin,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_sum,
    output logic         rsp_cout,
    output logic         rsp_err,
    output logic [2:0]   m_addr,
    output logic [N-1:0] m_data,
    output logic         m_we,
    output logic         m_start,
    input  logic [N-1:0] m_rdata,
    input  logic         m_ready,
    input  logic         m_ack
);

    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ADDR_DATA1  = 3'd1;
    localparam logic [2:0] ADDR_DATA2  = 3'd2;
    localparam logic [2:0] ADDR_CIN    = 3'd3;
    localparam logic [2:0] ADDR_RESULT = 3'd4;
    localparam logic [2:0] ADDR_COUT   = 3'd5;

    typedef enum logic [3:0] {
        IDLE,
        WR_D1,
        ACK_D1,
        WR_D2,
        ACK_D2,
        WR_CIN,
        ACK_CIN,
        START,
        WAIT_RDY,
        RD_RES,
        CAP_RES,
        RD_COUT,
        CAP_COUT,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [WW-1:0] wdog;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic          cin_q;
    logic          waiting;
    logic          expired;
    logic          timeout;

    // Watchdog only runs in the four wait states; it reads TIMEOUT-1 on the
    // TIMEOUT-th consecutive cycle spent there.
    always_comb begin
        waiting = (state == ACK_D1) || (state == ACK_D2) ||
                  (state == ACK_CIN) || (state == WAIT_RDY);
        expired = (wdog == WW'(TIMEOUT - 1));
    end

    // Next-state logic; an awaited signal arriving on the last allowed cycle wins.
    always_comb begin
        state_nx = state;
        timeout  = 1'b0;
        case (state)
            IDLE:     if (req_valid) state_nx = WR_D1;
            WR_D1:    state_nx = ACK_D1;
            ACK_D1: begin
                if (m_ack)        state_nx = WR_D2;
                else if (expired) timeout  = 1'b1;
            end
            WR_D2:    state_nx = ACK_D2;
            ACK_D2: begin
                if (m_ack)        state_nx = WR_CIN;
                else if (expired) timeout  = 1'b1;
            end
            WR_CIN:   state_nx = ACK_CIN;
            ACK_CIN: begin
                if (m_ack)        state_nx = START;
                else if (expired) timeout  = 1'b1;
            end
            START:    state_nx = WAIT_RDY;
            WAIT_RDY: begin
                if (m_ready)      state_nx = RD_RES;
                else if (expired) timeout  = 1'b1;
            end
            RD_RES:   state_nx = CAP_RES;
            CAP_RES:  state_nx = RD_COUT;
            RD_COUT:  state_nx = CAP_COUT;
            CAP_COUT: state_nx = RESP;
            RESP:     if (rsp_ready) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        if (timeout) state_nx = RESP;
    end

    // Moore outputs: bus signals are a pure function of the state register.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        m_addr    = 3'd0;
        m_data    = '0;
        m_we      = 1'b0;
        m_start   = 1'b0;
        case (state)
            IDLE:     req_ready = 1'b1;
            WR_D1: begin
                m_addr = ADDR_DATA1;
                m_data = a_q;
                m_we   = 1'b1;
            end
            ACK_D1: begin
                m_addr = ADDR_DATA1;
                m_data = a_q;
            end
            WR_D2: begin
                m_addr = ADDR_DATA2;
                m_data = b_q;
                m_we   = 1'b1;
            end
            ACK_D2: begin
                m_addr = ADDR_DATA2;
                m_data = b_q;
            end
            WR_CIN: begin
                m_addr = ADDR_CIN;
                m_data = {{(N-1){1'b0}}, cin_q};
                m_we   = 1'b1;
            end
            ACK_CIN: begin
                m_addr = ADDR_CIN;
                m_data = {{(N-1){1'b0}}, cin_q};
            end
            START:    m_start = 1'b1;
            RD_RES,
            CAP_RES:  m_addr = ADDR_RESULT;
            RD_COUT,
            CAP_COUT: m_addr = ADDR_COUT;
            RESP:     rsp_valid = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
            wdog  <= '0;
        end else begin
            state <= state_nx;
            if (waiting && (state_nx == state))
                wdog <= wdog + 1'b1;
            else
                wdog <= '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
        end else if ((state == IDLE) && req_valid) begin
            a_q   <= req_a;
            b_q   <= req_b;
            cin_q <= req_cin;
        end
    end

    // Response fields are only meaningful while rsp_valid; a timeout zeroes the data.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_err  <= 1'b0;
        end else if (timeout) begin
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_err  <= 1'b1;
        end else if (state == CAP_RES) begin
            rsp_sum  <= m_rdata;
        end else if (state == CAP_COUT) begin
            rsp_cout <= m_rdata[0];
            rsp_err  <= 1'b0;
        end
    end

endmodule
